// File: rtl/reg_access_arbiter.sv
// reg_access_arbiter
//   Round-robin arbiter granting N_REQ requesters write access to a single
//   shared DATA_W-bit register. A requester may lock ownership across several
//   writes; an idle lock is forcibly released after LOCK_TMO cycles.
//
// Ports
//   clk        sole clock, rising edge
//   reset      asynchronous active-low reset
//   req_valid  per-requester write request
//   req_lock   per-requester request to keep ownership after the current write
//   req_data   write data, requester i at [i*DATA_W +: DATA_W]
//   req_ready  per-requester accept (combinational, one-hot or zero)
//   reg_q      shared register contents
//   upd        one-cycle pulse when reg_q shows newly written data
//   upd_id     index of the last writer
//   locked     high while a requester holds the lock
//   lock_tmo   one-cycle pulse when a lock is forcibly released
module reg_access_arbiter #(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 64,
    parameter int LOCK_TMO = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ-1:0]           req_lock,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic [DATA_W-1:0]          reg_q,
    output logic                       upd,
    output logic [$clog2(N_REQ)-1:0]   upd_id,
    output logic                       locked,
    output logic                       lock_tmo
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(LOCK_TMO) + 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TMO - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   owner, owner_nxt;
    logic [ID_W-1:0]   rr_ptr, rr_nxt;
    logic [CNT_W-1:0]  tmo_cnt, cnt_nxt;

    logic              win_found;
    logic [ID_W-1:0]   win_idx;
    logic [ID_W-1:0]   cand;

    logic [N_REQ-1:0]  grant;
    logic              do_write;
    logic [ID_W-1:0]   wr_id;
    logic              tmo_fire;
    logic [DATA_W-1:0] wr_data;

    // Round-robin search starting just after the last granted index, so the
    // previous winner is considered last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((32'(rr_ptr) + k) % 32'(N_REQ));
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
        cnt_nxt   = tmo_cnt;
        grant     = '0;
        do_write  = 1'b0;
        wr_id     = owner;
        tmo_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    grant[win_idx] = 1'b1;
                    do_write       = 1'b1;
                    wr_id          = win_idx;
                    rr_nxt         = win_idx;
                    if (req_lock[win_idx]) begin
                        state_nxt = LOCKED;
                        owner_nxt = win_idx;
                        cnt_nxt   = '0;
                    end
                end
            end
            LOCKED: begin
                if (req_valid[owner]) begin
                    grant[owner] = 1'b1;
                    do_write     = 1'b1;
                    wr_id        = owner;
                    rr_nxt       = owner;
                    if (req_lock[owner]) begin
                        cnt_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (!req_lock[owner]) begin
                    // Owner voluntarily released without writing.
                    state_nxt = IDLE;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = IDLE;
                    tmo_fire  = 1'b1;
                    rr_nxt    = owner;
                end else begin
                    cnt_nxt = tmo_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign wr_data = req_data[wr_id*DATA_W +: DATA_W];

    // Ready is forced low while reset is asserted, even with valid requests.
    assign req_ready = reset ? grant : '0;
    assign locked    = (state == LOCKED);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= ID_W'(N_REQ - 1);
            tmo_cnt  <= '0;
            reg_q    <= '0;
            upd      <= 1'b0;
            upd_id   <= '0;
            lock_tmo <= 1'b0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_nxt;
            tmo_cnt  <= cnt_nxt;
            upd      <= do_write;
            lock_tmo <= tmo_fire;
            if (do_write) begin
                reg_q  <= wr_data;
                upd_id <= wr_id;
            end
        end
    end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Testbench for reg_access_arbiter: directed stimulus with a write scoreboard.
module tb_reg_access_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   valid;
    logic [3:0]   lock;
    logic [63:0]  d [4];
    logic [255:0] req_data;
    logic [3:0]   req_ready;
    logic [63:0]  reg_q;
    logic         upd;
    logic [1:0]   upd_id;
    logic         locked;
    logic         lock_tmo;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  id;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int rr_exp [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    assign req_data = {d[3], d[2], d[1], d[0]};

    reg_access_arbiter #(
        .N_REQ    (4),
        .DATA_W   (64),
        .LOCK_TMO (16)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .req_valid (valid),
        .req_lock  (lock),
        .req_data  (req_data),
        .req_ready (req_ready),
        .reg_q     (reg_q),
        .upd       (upd),
        .upd_id    (upd_id),
        .locked    (locked),
        .lock_tmo  (lock_tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input int i);
        exp_t e;
        e.data = d[i];
        e.id   = 2'(i);
        sb.push_back(e);
    endtask

    // Monitor: every update pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (upd) begin
            if (sb.size() == 0) begin
                check("unexpected_upd", 64'(upd), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("wr_data", reg_q, mon_e.data);
                check("wr_id", 64'(upd_id), 64'(mon_e.id));
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        valid = '0;
        lock  = '0;
        for (int i = 0; i < 4; i++) d[i] = '0;

        // Reset held 3 cycles; ready must stay low even with requests.
        repeat (3) @(posedge clk);
        #1;
        valid = 4'hF;
        #1;
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_reg_q", reg_q, 64'd0);
        check("rst_locked", 64'(locked), 64'd0);
        check("rst_upd", 64'(upd), 64'd0);
        valid = '0;
        #2 rst_n = 1'b1;
        next_cycle();

        // Round-robin with all four requesting.
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < 4; i++) d[i] = 64'((c << 4) | i) + 64'h100;
            valid = 4'hF;
            #1;
            check("rr_ready", 64'(req_ready), 64'(1 << rr_exp[c]));
            expect_wr(rr_exp[c]);
            next_cycle();
        end
        valid = '0;

        // Single write by requester 2.
        d[2]  = 64'h14;
        valid = 4'b0100;
        #1;
        check("single_ready", 64'(req_ready), 64'h4);
        expect_wr(2);
        next_cycle();
        valid = '0;
        #1;
        check("single_upd", 64'(upd), 64'd1);
        check("single_idle_ready", 64'(req_ready), 64'd0);
        next_cycle();

        // Requester 3 writes so the pointer sits at 3 before the lock test.
        d[3]  = 64'h33;
        valid = 4'b1000;
        #1;
        check("r3_ready", 64'(req_ready), 64'h8);
        expect_wr(3);
        next_cycle();

        // Lock by requester 1 while requester 3 waits.
        d[1]  = 64'h0A;
        d[3]  = 64'h3C;
        valid = 4'b1010;
        lock  = 4'b0010;
        #1;
        check("lock_ready0", 64'(req_ready), 64'h2);
        check("lock_pre_locked", 64'(locked), 64'd0);
        expect_wr(1);
        next_cycle();
        d[1] = 64'h0B;
        #1;
        check("lock_locked1", 64'(locked), 64'd1);
        check("lock_stall1", 64'(req_ready), 64'h2);
        expect_wr(1);
        next_cycle();
        d[1] = 64'h0C;
        lock = 4'b0000;
        #1;
        check("lock_locked2", 64'(locked), 64'd1);
        check("lock_stall2", 64'(req_ready), 64'h2);
        expect_wr(1);
        next_cycle();
        #1;
        check("unlock_locked", 64'(locked), 64'd0);
        check("unlock_r3_grant", 64'(req_ready), 64'h8);
        expect_wr(3);
        next_cycle();
        valid = '0;
        lock  = '0;

        // Timeout: requester 0 locks and goes silent.
        d[0]  = 64'h55;
        valid = 4'b0001;
        lock  = 4'b0001;
        #1;
        check("tmo_lock_ready", 64'(req_ready), 64'h1);
        expect_wr(0);
        next_cycle();
        for (int k = 1; k <= 16; k++) begin
            valid = 4'b1000;
            lock  = 4'b0001;
            #1;
            check("tmo_locked", 64'(locked), 64'd1);
            check("tmo_no_pulse", 64'(lock_tmo), 64'd0);
            check("tmo_stall", 64'(req_ready), 64'd0);
            next_cycle();
        end
        valid = '0;
        #1;
        check("tmo_pulse", 64'(lock_tmo), 64'd1);
        check("tmo_released", 64'(locked), 64'd0);
        check("tmo_reg_q_hold", reg_q, 64'h55);
        next_cycle();
        lock = '0;
        #1;
        check("tmo_pulse_end", 64'(lock_tmo), 64'd0);

        // Reset in the middle of a locked write.
        d[1]  = 64'h11;
        valid = 4'b0010;
        lock  = 4'b0010;
        #1;
        check("mid_lock_ready", 64'(req_ready), 64'h2);
        expect_wr(1);
        next_cycle();
        d[1] = 64'h1E;
        #1;
        check("mid_locked", 64'(locked), 64'd1);
        check("mid_ready", 64'(req_ready), 64'h2);
        #4 rst_n = 1'b0;
        #1;
        check("async_rst_reg_q", reg_q, 64'd0);
        check("async_rst_locked", 64'(locked), 64'd0);
        check("async_rst_ready", 64'(req_ready), 64'd0);
        next_cycle();
        check("rst_hold_reg_q", reg_q, 64'd0);
        valid = '0;
        lock  = '0;
        #2 rst_n = 1'b1;
        next_cycle();
        #1;
        check("post_rst_reg_q", reg_q, 64'd0);
        check("post_rst_upd", 64'(upd), 64'd0);

        // First arbitration after reset favours requester 0.
        for (int i = 0; i < 4; i++) d[i] = 64'h70 + 64'(i);
        valid = 4'hF;
        #1;
        check("post_rst_grant0", 64'(req_ready), 64'h1);
        expect_wr(0);
        next_cycle();
        valid = '0;
        next_cycle();
        next_cycle();
        check("sb_drain", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
